// File: rtl/ofdm_rx_frame_sequencer.sv
// Receive-side frame sequencer: arms frame detection, walks a packet through
// LTS / SIGNAL / DATA by counting valid samples, then re-arms after a guard gap.
module ofdm_rx_frame_sequencer #(
   parameter int unsigned SYM_LEN     = 80,
   parameter int unsigned LTS_LEN     = 160,
   parameter int unsigned SIG_TIMEOUT = 256,
   parameter int unsigned GUARD_CYC   = 16
) (
   input  logic       Clk,
   input  logic       Rst,
   input  logic       SampleValid,
   input  logic       FrameFinded,
   input  logic       SignalValid,
   input  logic       SignalParityOk,
   input  logic [7:0] SymbolCount,
   output logic       FrameDetectionEnable,
   output logic       DataBufferOutputEnable,
   output logic [1:0] Phase,
   output logic       SymbolStart,
   output logic [7:0] SymbolIndex,
   output logic       FrameDone,
   output logic       FrameAbort
);

   localparam int unsigned SCNT_W = $clog2((LTS_LEN > SYM_LEN) ? LTS_LEN : SYM_LEN);
   localparam int unsigned CCNT_W = $clog2((SIG_TIMEOUT > GUARD_CYC) ? SIG_TIMEOUT : GUARD_CYC);

   localparam logic [2:0] IDLE     = 3'd0;
   localparam logic [2:0] SEARCH   = 3'd1;
   localparam logic [2:0] LTS      = 3'd2;
   localparam logic [2:0] SIGNAL   = 3'd3;
   localparam logic [2:0] WAIT_SIG = 3'd4;
   localparam logic [2:0] DATA     = 3'd5;
   localparam logic [2:0] GUARD    = 3'd6;

   logic [2:0]        state, state_nx;
   logic [SCNT_W-1:0] scnt, scnt_nx;
   logic [CCNT_W-1:0] ccnt, ccnt_nx;
   logic [7:0]        remaining, remaining_nx;
   logic [7:0]        idx_nx;
   logic              start_nx, done_nx, abort_nx;
   logic              fde_nx, dboe_nx;
   logic [1:0]        phase_nx;

   // Next-state, counter and next-output logic; outputs follow the next state.
   always_comb begin
      state_nx     = state;
      scnt_nx      = scnt;
      ccnt_nx      = ccnt;
      remaining_nx = remaining;
      idx_nx       = SymbolIndex;
      start_nx     = 1'b0;
      done_nx      = 1'b0;
      abort_nx     = 1'b0;
      case (state)
         IDLE: state_nx = SEARCH;
         SEARCH: begin
            if (FrameFinded) begin
               state_nx = LTS;
               scnt_nx  = '0;
            end
         end
         LTS: begin
            if (SampleValid) begin
               if (scnt == SCNT_W'(LTS_LEN - 1)) begin
                  state_nx = SIGNAL;
                  scnt_nx  = '0;
               end else begin
                  scnt_nx = scnt + 1'b1;
               end
            end
         end
         SIGNAL: begin
            if (SampleValid) begin
               start_nx = (scnt == '0);
               if (scnt == SCNT_W'(SYM_LEN - 1)) begin
                  state_nx = WAIT_SIG;
                  scnt_nx  = '0;
                  ccnt_nx  = '0;
               end else begin
                  scnt_nx = scnt + 1'b1;
               end
            end
         end
         WAIT_SIG: begin
            // A decode arriving on the final timeout cycle still wins.
            if (SignalValid) begin
               if (SignalParityOk && (SymbolCount != 8'd0)) begin
                  state_nx     = DATA;
                  remaining_nx = SymbolCount;
                  idx_nx       = 8'd0;
                  scnt_nx      = '0;
               end else begin
                  state_nx = GUARD;
                  abort_nx = 1'b1;
                  ccnt_nx  = '0;
               end
            end else if (ccnt == CCNT_W'(SIG_TIMEOUT - 1)) begin
               state_nx = GUARD;
               abort_nx = 1'b1;
               ccnt_nx  = '0;
            end else begin
               ccnt_nx = ccnt + 1'b1;
            end
         end
         DATA: begin
            if (SampleValid) begin
               start_nx = (scnt == '0);
               if (scnt == SCNT_W'(SYM_LEN - 1)) begin
                  scnt_nx = '0;
                  if (remaining == 8'd1) begin
                     state_nx     = GUARD;
                     done_nx      = 1'b1;
                     idx_nx       = 8'd0;
                     remaining_nx = 8'd0;
                     ccnt_nx      = '0;
                  end else begin
                     idx_nx       = SymbolIndex + 8'd1;
                     remaining_nx = remaining - 8'd1;
                  end
               end else begin
                  scnt_nx = scnt + 1'b1;
               end
            end
         end
         GUARD: begin
            if (ccnt == CCNT_W'(GUARD_CYC - 1)) begin
               state_nx = SEARCH;
            end else begin
               ccnt_nx = ccnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase

      fde_nx  = (state_nx == SEARCH);
      dboe_nx = (state_nx == LTS) || (state_nx == SIGNAL) || (state_nx == DATA);
      case (state_nx)
         LTS:     phase_nx = 2'd1;
         SIGNAL:  phase_nx = 2'd2;
         DATA:    phase_nx = 2'd3;
         default: phase_nx = 2'd0;
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state                  <= IDLE;
         scnt                   <= '0;
         ccnt                   <= '0;
         remaining              <= 8'd0;
         FrameDetectionEnable   <= 1'b0;
         DataBufferOutputEnable <= 1'b0;
         Phase                  <= 2'd0;
         SymbolStart            <= 1'b0;
         SymbolIndex            <= 8'd0;
         FrameDone              <= 1'b0;
         FrameAbort             <= 1'b0;
      end else begin
         state                  <= state_nx;
         scnt                   <= scnt_nx;
         ccnt                   <= ccnt_nx;
         remaining              <= remaining_nx;
         FrameDetectionEnable   <= fde_nx;
         DataBufferOutputEnable <= dboe_nx;
         Phase                  <= phase_nx;
         SymbolStart            <= start_nx;
         SymbolIndex            <= idx_nx;
         FrameDone              <= done_nx;
         FrameAbort             <= abort_nx;
      end
   end

endmodule

// File: tb/tb_ofdm_rx_frame_sequencer.sv
// Directed bench for ofdm_rx_frame_sequencer.
module tb_ofdm_rx_frame_sequencer;

   localparam int SYM_LEN = 80;

   logic       Clk = 1'b0;
   logic       Rst;
   logic       SampleValid;
   logic       FrameFinded;
   logic       SignalValid;
   logic       SignalParityOk;
   logic [7:0] SymbolCount;
   logic       FrameDetectionEnable;
   logic       DataBufferOutputEnable;
   logic [1:0] Phase;
   logic       SymbolStart;
   logic [7:0] SymbolIndex;
   logic       FrameDone;
   logic       FrameAbort;

   ofdm_rx_frame_sequencer dut (
      .Clk(Clk), .Rst(Rst), .SampleValid(SampleValid), .FrameFinded(FrameFinded),
      .SignalValid(SignalValid), .SignalParityOk(SignalParityOk), .SymbolCount(SymbolCount),
      .FrameDetectionEnable(FrameDetectionEnable), .DataBufferOutputEnable(DataBufferOutputEnable),
      .Phase(Phase), .SymbolStart(SymbolStart), .SymbolIndex(SymbolIndex),
      .FrameDone(FrameDone), .FrameAbort(FrameAbort)
   );

   // 10-unit clock.
   always #5 Clk = ~Clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Per-frame tallies.
   int         val_cnt [4];
   int         dboe_cyc, ss_cnt, done_cnt, abort_cnt, inv_bad;
   logic [7:0] idx_q [$];
   logic       tog = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic clear_tally();
      for (int i = 0; i < 4; i++) val_cnt[i] = 0;
      dboe_cyc = 0; ss_cnt = 0; done_cnt = 0; abort_cnt = 0; inv_bad = 0;
      idx_q.delete();
   endtask

   // One clock: tally the presented sample, then observe outputs 1 unit after the edge.
   task automatic tick();
      int         pos;
      logic       sv;
      logic [1:0] ph;
      sv  = SampleValid;
      ph  = Phase;
      pos = val_cnt[ph];
      if (sv) val_cnt[ph]++;
      @(posedge Clk);
      #1;
      if (DataBufferOutputEnable) dboe_cyc++;
      if (FrameDone) done_cnt++;
      if (FrameAbort) abort_cnt++;
      if (FrameDone && FrameAbort) inv_bad++;
      if (SymbolStart) begin
         ss_cnt++;
         if (!(sv && (ph == 2'd2 || ph == 2'd3) && (pos % SYM_LEN == 0) && Phase == ph)) inv_bad++;
         if (Phase == 2'd3) idx_q.push_back(SymbolIndex);
      end
      if (tog) SampleValid = ~SampleValid;
   endtask

   // Drive one frame from SEARCH; d<=0 means SignalValid is never given.
   task automatic run_frame(input logic tg, input logic [7:0] cnt, input logic par, input int d,
                            input logic ff_guard, output int wait_n, output int guard_n);
      int b;
      clear_tally();
      tog = tg;
      FrameFinded = 1'b1;
      tick();
      FrameFinded = 1'b0;
      b = 0;
      while (Phase != 2'd0 && b < 2000) begin tick(); b++; end
      wait_n = 0;
      if (d > 0) begin
         repeat (d - 1) tick();
         SignalValid = 1'b1; SignalParityOk = par; SymbolCount = cnt;
         tick();
         SignalValid = 1'b0; SignalParityOk = 1'b0; SymbolCount = 8'd0;
         wait_n = d;
      end
      b = 0;
      while (done_cnt + abort_cnt == 0 && b < 50000) begin
         tick(); b++;
         if (d <= 0) wait_n++;
      end
      guard_n = 0;
      if (ff_guard) FrameFinded = 1'b1;
      while (!FrameDetectionEnable && guard_n < 100) begin
         tick();
         FrameFinded = 1'b0;
         guard_n++;
         if (Phase != 2'd0) inv_bad++;
      end
      tog = 1'b0;
      SampleValid = 1'b1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_fde"},   32'(FrameDetectionEnable), 0);
      check({tag, "_dboe"},  32'(DataBufferOutputEnable), 0);
      check({tag, "_phase"}, 32'(Phase), 0);
      check({tag, "_ss"},    32'(SymbolStart), 0);
      check({tag, "_idx"},   32'(SymbolIndex), 0);
      check({tag, "_done"},  32'(FrameDone), 0);
      check({tag, "_abort"}, 32'(FrameAbort), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w, g, b, bad;
      Rst = 1'b1; SampleValid = 1'b1; FrameFinded = 1'b0;
      SignalValid = 1'b0; SignalParityOk = 1'b0; SymbolCount = 8'd0;
      clear_tally();

      // Reset state and release.
      repeat (3) @(posedge Clk);
      #1;
      check_outputs_zero("rst");
      Rst = 1'b0;
      tick();
      check("rel_fde", 32'(FrameDetectionEnable), 1);
      check("rel_dboe", 32'(DataBufferOutputEnable), 0);

      // Continuous samples, 3 symbols, SignalValid on WAIT_SIG cycle 5.
      run_frame(1'b0, 8'd3, 1'b1, 5, 1'b0, w, g);
      check("c_lts", val_cnt[1], 160);
      check("c_sig", val_cnt[2], 80);
      check("c_data", val_cnt[3], 240);
      check("c_dboe", dboe_cyc, 480);
      check("c_ss", ss_cnt, 4);
      check("c_idxn", idx_q.size(), 3);
      for (int i = 0; i < 3 && i < idx_q.size(); i++) check("c_idx", 32'(idx_q[i]), i);
      check("c_done", done_cnt, 1);
      check("c_abort", abort_cnt, 0);
      check("c_guard", g, 16);
      check("c_inv", inv_bad, 0);
      check("c_idx_after", 32'(SymbolIndex), 0);

      // Toggling samples through the same frame.
      SampleValid = 1'b1;
      run_frame(1'b1, 8'd3, 1'b1, 5, 1'b0, w, g);
      check("t_lts", val_cnt[1], 160);
      check("t_sig", val_cnt[2], 80);
      check("t_data", val_cnt[3], 240);
      check("t_ss", ss_cnt, 4);
      check("t_idxn", idx_q.size(), 3);
      for (int i = 0; i < 3 && i < idx_q.size(); i++) check("t_idx", 32'(idx_q[i]), i);
      check("t_done", done_cnt, 1);
      check("t_inv", inv_bad, 0);

      // Parity fail, FrameFinded pulsed in GUARD must be ignored.
      run_frame(1'b0, 8'd3, 1'b0, 3, 1'b1, w, g);
      check("p_abort", abort_cnt, 1);
      check("p_done", done_cnt, 0);
      check("p_data", val_cnt[3], 0);
      check("p_guard", g, 16);
      check("p_inv", inv_bad, 0);

      // Zero symbol count.
      run_frame(1'b0, 8'd0, 1'b1, 2, 1'b0, w, g);
      check("z_abort", abort_cnt, 1);
      check("z_done", done_cnt, 0);
      check("z_data", val_cnt[3], 0);
      check("z_guard", g, 16);

      // Timeout with no SignalValid.
      run_frame(1'b0, 8'd0, 1'b0, 0, 1'b0, w, g);
      check("to_abort", abort_cnt, 1);
      check("to_cycles", w, 256);
      check("to_data", val_cnt[3], 0);
      check("to_guard", g, 16);

      // SignalValid on the final timeout cycle wins.
      run_frame(1'b0, 8'd1, 1'b1, 256, 1'b0, w, g);
      check("tb_abort", abort_cnt, 0);
      check("tb_done", done_cnt, 1);
      check("tb_data", val_cnt[3], 80);
      check("tb_inv", inv_bad, 0);

      // Maximum symbol count runs every symbol without wrap.
      run_frame(1'b0, 8'd255, 1'b1, 1, 1'b0, w, g);
      check("m_data", val_cnt[3], 255 * 80);
      check("m_idxn", idx_q.size(), 255);
      bad = 0;
      for (int i = 0; i < idx_q.size(); i++) if (idx_q[i] != 8'(i)) bad++;
      check("m_idxseq", bad, 0);
      check("m_done", done_cnt, 1);
      check("m_inv", inv_bad, 0);

      // Reset mid-DATA at SymbolIndex 2, with FrameFinded ignored in DATA.
      clear_tally();
      FrameFinded = 1'b1;
      tick();
      FrameFinded = 1'b0;
      b = 0;
      while (Phase != 2'd0 && b < 2000) begin tick(); b++; end
      SignalValid = 1'b1; SignalParityOk = 1'b1; SymbolCount = 8'd5;
      tick();
      SignalValid = 1'b0; SignalParityOk = 1'b0; SymbolCount = 8'd0;
      FrameFinded = 1'b1;
      tick();
      FrameFinded = 1'b0;
      check("r_ff_ignored", 32'(Phase), 3);
      b = 0;
      while (SymbolIndex != 8'd2 && b < 5000) begin tick(); b++; end
      check("r_idx2", 32'(SymbolIndex), 2);
      #2;
      Rst = 1'b1;
      #1;
      check_outputs_zero("r_async");
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      tick();
      check("r_fde", 32'(FrameDetectionEnable), 1);
      check("r_phase", 32'(Phase), 0);
      check("r_done", done_cnt, 0);
      check("r_abort", abort_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
